id_ex_register: RTL and testbench

Decode-to-execute pipeline register of the 5-stage RV32I core. It sits directly downstream of `control_decoder`. It captures that block's control bundle together with decoded operands, PC, immediate and register addresses, and presents them to the execute stage one cycle later. It also detects load-use hazards against the instruction currently in EX and inserts exactly one bubble. It honours an EX-stage hold and a branch/jump flush, and counts inserted bubbles for performance monitoring.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/hazard_detection_unit.sv | 32 +++
 rtl/id_ex_register.sv | 155 +++++++++++++++
 tb/tb_id_ex_register.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the RV32I core pipeline: the control bundle produced by
// control_decoder and carried down the pipeline registers.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic       write;
    logic       store;
    logic       load;
    logic       branch;
    logic [1:0] alu_operand_a_selector;
    logic       alu_operand_b_selector;
    logic [1:0] next_pc_selector;
    logic [2:0] alu_operations_selector;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detection_unit.sv
// Combinational load-use detector: flags an ID consumer of a load result still
// in EX, and decides whether upstream must freeze this cycle.
module hazard_detection_unit
  import cpu_pkg::*;
(
  input  logic                  ex_valid,
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  flush,
  input  logic                  ex_stall,
  output logic                  load_use,
  output logic                  hazard_stall
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_rs1_used && (id_rs1_addr == ex_rd_addr);
  assign rs2_match = id_rs2_used && (id_rs2_addr == ex_rd_addr);

  // x0 is never a real destination, so a load into x0 cannot create a hazard.
  assign load_use = ex_valid && ex_load && (ex_rd_addr != '0) && id_valid
                    && (rs1_match || rs2_match);

  assign hazard_stall = load_use && !flush && !ex_stall;

endmodule

// File: rtl/id_ex_register.sv
// ID->EX pipeline register with load-use bubble insertion, EX hold, flush and a
// saturating count of inserted bubbles.
module id_ex_register
  import cpu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BUBBLE_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic                    id_write,
  input  logic                    id_store,
  input  logic                    id_load,
  input  logic                    id_branch,
  input  logic [1:0]              id_alu_operand_a_selector,
  input  logic                    id_alu_operand_b_selector,
  input  logic [1:0]              id_next_pc_selector,
  input  logic [2:0]              id_alu_operations_selector,
  input  logic [XLEN-1:0]         id_pc,
  input  logic [XLEN-1:0]         id_rs1_data,
  input  logic [XLEN-1:0]         id_rs2_data,
  input  logic [XLEN-1:0]         id_immediate,
  input  logic [4:0]              id_rs1_addr,
  input  logic [4:0]              id_rs2_addr,
  input  logic [4:0]              id_rd_addr,
  input  logic                    id_rs1_used,
  input  logic                    id_rs2_used,
  input  logic                    ex_stall,
  input  logic                    flush,
  output logic                    ex_write,
  output logic                    ex_store,
  output logic                    ex_load,
  output logic                    ex_branch,
  output logic [1:0]              ex_alu_operand_a_selector,
  output logic                    ex_alu_operand_b_selector,
  output logic [1:0]              ex_next_pc_selector,
  output logic [2:0]              ex_alu_operations_selector,
  output logic [XLEN-1:0]         ex_pc,
  output logic [XLEN-1:0]         ex_rs1_data,
  output logic [XLEN-1:0]         ex_rs2_data,
  output logic [XLEN-1:0]         ex_immediate,
  output logic [4:0]              ex_rs1_addr,
  output logic [4:0]              ex_rs2_addr,
  output logic [4:0]              ex_rd_addr,
  output logic                    ex_valid,
  output logic                    hazard_stall,
  output logic [BUBBLE_CNT_W-1:0] bubble_count
);

  ctrl_t                     id_ctrl;
  ctrl_t                     ex_ctrl_reg;
  logic                      ex_valid_reg;
  logic [XLEN-1:0]           ex_pc_reg;
  logic [XLEN-1:0]           ex_rs1_data_reg;
  logic [XLEN-1:0]           ex_rs2_data_reg;
  logic [XLEN-1:0]           ex_immediate_reg;
  logic [REG_ADDR_W-1:0]     ex_rs1_addr_reg;
  logic [REG_ADDR_W-1:0]     ex_rs2_addr_reg;
  logic [REG_ADDR_W-1:0]     ex_rd_addr_reg;
  logic [BUBBLE_CNT_W-1:0]   bubble_count_reg;
  logic                      load_use;
  logic                      load_fields;

  assign id_ctrl = '{
    write:                   id_write,
    store:                   id_store,
    load:                    id_load,
    branch:                  id_branch,
    alu_operand_a_selector:  id_alu_operand_a_selector,
    alu_operand_b_selector:  id_alu_operand_b_selector,
    next_pc_selector:        id_next_pc_selector,
    alu_operations_selector: id_alu_operations_selector
  };

  hazard_detection_unit u_hazard (
    .ex_valid     (ex_valid_reg),
    .ex_load      (ex_ctrl_reg.load),
    .ex_rd_addr   (ex_rd_addr_reg),
    .id_valid     (id_valid),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .flush        (flush),
    .ex_stall     (ex_stall),
    .load_use     (load_use),
    .hazard_stall (hazard_stall)
  );

  // Payload fields follow ID on a flush too (contents are dead) and on a normal
  // advance; they hold across an EX stall and across an inserted bubble.
  assign load_fields = flush || (!ex_stall && !load_use);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg     <= 1'b0;
      ex_ctrl_reg      <= CTRL_NOP;
      ex_pc_reg        <= '0;
      ex_rs1_data_reg  <= '0;
      ex_rs2_data_reg  <= '0;
      ex_immediate_reg <= '0;
      ex_rs1_addr_reg  <= '0;
      ex_rs2_addr_reg  <= '0;
      ex_rd_addr_reg   <= '0;
      bubble_count_reg <= '0;
    end else begin
      if (flush) begin
        ex_valid_reg <= 1'b0;
        ex_ctrl_reg  <= CTRL_NOP;
      end else if (ex_stall) begin
        ex_valid_reg <= ex_valid_reg;
        ex_ctrl_reg  <= ex_ctrl_reg;
      end else if (load_use) begin
        ex_valid_reg <= 1'b0;
        ex_ctrl_reg  <= CTRL_NOP;
        if (bubble_count_reg != '1) begin
          bubble_count_reg <= bubble_count_reg + 1'b1;
        end
      end else begin
        ex_valid_reg <= id_valid;
        ex_ctrl_reg  <= id_valid ? id_ctrl : CTRL_NOP;
      end

      if (load_fields) begin
        ex_pc_reg        <= id_pc;
        ex_rs1_data_reg  <= id_rs1_data;
        ex_rs2_data_reg  <= id_rs2_data;
        ex_immediate_reg <= id_immediate;
        ex_rs1_addr_reg  <= id_rs1_addr;
        ex_rs2_addr_reg  <= id_rs2_addr;
        ex_rd_addr_reg   <= id_rd_addr;
      end
    end
  end

  assign ex_valid                   = ex_valid_reg;
  assign ex_write                   = ex_ctrl_reg.write;
  assign ex_store                   = ex_ctrl_reg.store;
  assign ex_load                    = ex_ctrl_reg.load;
  assign ex_branch                  = ex_ctrl_reg.branch;
  assign ex_alu_operand_a_selector  = ex_ctrl_reg.alu_operand_a_selector;
  assign ex_alu_operand_b_selector  = ex_ctrl_reg.alu_operand_b_selector;
  assign ex_next_pc_selector        = ex_ctrl_reg.next_pc_selector;
  assign ex_alu_operations_selector = ex_ctrl_reg.alu_operations_selector;
  assign ex_pc                      = ex_pc_reg;
  assign ex_rs1_data                = ex_rs1_data_reg;
  assign ex_rs2_data                = ex_rs2_data_reg;
  assign ex_immediate               = ex_immediate_reg;
  assign ex_rs1_addr                = ex_rs1_addr_reg;
  assign ex_rs2_addr                = ex_rs2_addr_reg;
  assign ex_rd_addr                 = ex_rd_addr_reg;
  assign bubble_count               = bubble_count_reg;

endmodule

// File: tb/tb_id_ex_register.sv
// Randomized scoreboard bench for id_ex_register: a behavioural model predicts
// each cycle's hazard_stall and post-edge EX contents; a monitor compares them.
module tb_id_ex_register;
  import cpu_pkg::*;

  localparam int XLEN = 32;
  // Narrow counter so saturation is reachable in a short run.
  localparam int BW   = 10;
  localparam int CMAX = (1 << BW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            id_valid, id_write, id_store, id_load, id_branch;
  logic [1:0]      id_a_sel, id_npc_sel;
  logic            id_b_sel;
  logic [2:0]      id_op;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_immediate;
  logic [4:0]      id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic            id_rs1_used, id_rs2_used, ex_stall, flush;
  logic            ex_write, ex_store, ex_load, ex_branch;
  logic [1:0]      ex_a_sel, ex_npc_sel;
  logic            ex_b_sel;
  logic [2:0]      ex_op;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_immediate;
  logic [4:0]      ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic            ex_valid, hazard_stall;
  logic [BW-1:0]   bubble_count;

  always #5 clk = ~clk;

  id_ex_register #(.XLEN(XLEN), .BUBBLE_CNT_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_write(id_write), .id_store(id_store), .id_load(id_load), .id_branch(id_branch),
    .id_alu_operand_a_selector(id_a_sel), .id_alu_operand_b_selector(id_b_sel),
    .id_next_pc_selector(id_npc_sel), .id_alu_operations_selector(id_op),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_immediate(id_immediate), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_stall(ex_stall), .flush(flush),
    .ex_write(ex_write), .ex_store(ex_store), .ex_load(ex_load), .ex_branch(ex_branch),
    .ex_alu_operand_a_selector(ex_a_sel), .ex_alu_operand_b_selector(ex_b_sel),
    .ex_next_pc_selector(ex_npc_sel), .ex_alu_operations_selector(ex_op),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_immediate(ex_immediate), .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rd_addr(ex_rd_addr), .ex_valid(ex_valid), .hazard_stall(hazard_stall),
    .bubble_count(bubble_count)
  );

  typedef struct {
    logic            hs;
    logic            valid;
    ctrl_t           ctrl;
    logic [XLEN-1:0] pc, r1d, r2d, imm;
    logic [4:0]      r1a, r2a, rda;
    int              cnt;
  } exp_t;

  exp_t m;          // model of what EX holds now
  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cycle_no = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle_no, act, exp);
    end
  endtask

  function automatic ctrl_t id_ctrl_now();
    ctrl_t c;
    c.write = id_write; c.store = id_store; c.load = id_load; c.branch = id_branch;
    c.alu_operand_a_selector = id_a_sel; c.alu_operand_b_selector = id_b_sel;
    c.next_pc_selector = id_npc_sel; c.alu_operations_selector = id_op;
    return c;
  endfunction

  function automatic exp_t model_clear();
    exp_t z;
    z.hs = 0; z.valid = 0; z.ctrl = '0; z.pc = 0; z.r1d = 0; z.r2d = 0; z.imm = 0;
    z.r1a = 0; z.r2a = 0; z.rda = 0; z.cnt = 0;
    return z;
  endfunction

  // Predict this cycle's stall and the state after the coming edge.
  task automatic model_step();
    bit   consumer, lu;
    exp_t e;
    consumer = id_valid && ((id_rs1_used && id_rs1_addr == m.rda) ||
                            (id_rs2_used && id_rs2_addr == m.rda));
    lu = m.valid && m.ctrl.load && m.rda != 0 && consumer;
    e = m;
    e.hs = lu && !flush && !ex_stall;
    if (flush) begin
      e.valid = 0; e.ctrl = '0;
    end else if (ex_stall) begin
      // nothing moves
    end else if (lu) begin
      e.valid = 0; e.ctrl = '0;
      if (e.cnt < CMAX) e.cnt = e.cnt + 1;
    end else begin
      e.valid = id_valid;
      e.ctrl  = id_valid ? id_ctrl_now() : '0;
      e.pc = id_pc; e.r1d = id_rs1_data; e.r2d = id_rs2_data; e.imm = id_immediate;
      e.r1a = id_rs1_addr; e.r2a = id_rs2_addr; e.rda = id_rd_addr;
    end
    q.push_back(e);
    m = e;
    m.hs = 0;
  endtask

  task automatic randomize_inputs();
    id_valid = ($urandom_range(0, 7) != 0);
    {id_write, id_store, id_branch} = 3'($urandom);
    id_load = ($urandom_range(0, 2) == 0);
    id_a_sel = 2'($urandom); id_b_sel = 1'($urandom);
    id_npc_sel = 2'($urandom); id_op = 3'($urandom);
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_immediate = $urandom;
    id_rs1_addr = 5'($urandom_range(0, 3)); id_rs2_addr = 5'($urandom_range(0, 3));
    id_rd_addr  = 5'($urandom_range(0, 3));
    id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
    flush    = ($urandom_range(0, 7) == 0);
    ex_stall = ($urandom_range(0, 5) == 0);
  endtask

  task automatic set_addi_rd5();
    id_valid = 1; id_write = 1; id_store = 0; id_load = 0; id_branch = 0;
    id_a_sel = 2'd0; id_b_sel = 1; id_npc_sel = 2'd0; id_op = 3'd0;
    id_pc = 32'h0000_1000; id_rs1_data = 32'h11; id_rs2_data = 32'h22; id_immediate = 32'h7;
    id_rs1_addr = 5'd1; id_rs2_addr = 5'd0; id_rd_addr = 5'd5;
    id_rs1_used = 1; id_rs2_used = 0; flush = 0; ex_stall = 0;
  endtask

  task automatic slot();
    @(posedge clk);
    #2;
    cycle_no++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ex_valid"}, 64'(ex_valid), 64'(0));
    chk({tag, "_ex_ctrl"}, 64'({ex_write, ex_store, ex_load, ex_branch, ex_a_sel, ex_b_sel,
                                ex_npc_sel, ex_op}), 64'(0));
    chk({tag, "_ex_data"}, 64'(ex_pc | ex_rs1_data | ex_rs2_data | ex_immediate), 64'(0));
    chk({tag, "_ex_addr"}, 64'({ex_rs1_addr, ex_rs2_addr, ex_rd_addr}), 64'(0));
    chk({tag, "_bubble_count"}, 64'(bubble_count), 64'(0));
    chk({tag, "_hazard_stall"}, 64'(hazard_stall), 64'(0));
  endtask

  // Monitor: sample stall mid-cycle, EX state just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hazard_stall", 64'(hazard_stall), 64'(e.hs));
        @(posedge clk);
        #1;
        chk("ex_valid", 64'(ex_valid), 64'(e.valid));
        chk("ex_ctrl", 64'({ex_write, ex_store, ex_load, ex_branch, ex_a_sel, ex_b_sel,
                            ex_npc_sel, ex_op}), 64'(e.ctrl));
        chk("bubble_count", 64'(bubble_count), 64'(e.cnt));
        if (e.valid) begin
          chk("ex_pc", 64'(ex_pc), 64'(e.pc));
          chk("ex_operands", {ex_rs1_data, ex_rs2_data}, {e.r1d, e.r2d});
          chk("ex_immediate", 64'(ex_immediate), 64'(e.imm));
          chk("ex_addrs", 64'({ex_rs1_addr, ex_rs2_addr, ex_rd_addr}),
              64'({e.r1a, e.r2a, e.rda}));
        end
      end
    end
  end

  initial begin
    m = model_clear();
    // Reset asserted with random inputs.
    randomize_inputs();
    #1;
    check_reset_outputs("reset");
    repeat (3) slot();
    randomize_inputs();
    check_reset_outputs("reset_held");

    // Release and present ADDI x5.
    rst_n = 1;
    set_addi_rd5();
    model_step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      slot();
      randomize_inputs();
      model_step();
    end

    // Mid-run asynchronous reset.
    slot();
    randomize_inputs();
    rst_n = 0;
    #1;
    check_reset_outputs("midreset");
    m = model_clear();
    slot();
    rst_n = 1;
    set_addi_rd5();
    model_step();

    // Back-to-back load-use pairs: LW x5 reading x5 repeatedly until saturation.
    for (int i = 0; i < 2 * (CMAX + 6); i++) begin
      slot();
      set_addi_rd5();
      id_write = 0; id_load = 1; id_rs1_addr = 5'd5;
      model_step();
    end

    slot();
    randomize_inputs();
    flush = 0; ex_stall = 0;
    model_step();
    repeat (3) slot();
    chk("bubble_saturated", 64'(bubble_count), 64'(CMAX));
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
